// File: rtl/target_box_scheduler.sv
// Frame-synchronous overlay scheduler: round-robin box intake from NUM_REQ detectors,
// area ranking into a top-2 list, and per-frame commit of two persistent overlay slots.
module target_box_scheduler #(
  parameter int NUM_REQ     = 2,
  parameter int HOLD_FRAMES = 8,
  parameter int IMG_HDISP   = 1280,
  parameter int IMG_VDISP   = 720
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  per_frame_vsync,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*42-1:0] req_box,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [42:0]           target_pos_out1,
  output logic [42:0]           target_pos_out2,
  output logic                  frame_commit,
  output logic [7:0]            drop_cnt
);
  localparam int unsigned NR   = NUM_REQ;
  localparam int          PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [11:0] HLIM = 12'(IMG_HDISP);
  localparam logic [10:0] VLIM = 11'(IMG_VDISP);
  localparam logic [7:0]  HOLD = 8'(HOLD_FRAMES);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, COMMIT} state_t;

  state_t       state_q, state_d;
  logic         vs_q, vs_prev_q, rise, fall;
  logic         pend_q, pend_d;
  logic         drain_q, drain_d;
  logic         collect_start;
  logic [PW-1:0] rr_q, rr_d;
  logic [NR-1:0] gnt;
  logic [41:0]  gnt_box;
  logic         found;
  int unsigned  pos;

  logic         s1_v_q, s1_ok;
  logic [41:0]  s1_box_q;
  logic [10:0]  w, h;
  logic [20:0]  area;
  logic         s2_v_q;
  logic [41:0]  s2_box_q;
  logic [20:0]  s2_area_q;

  logic         a_v_q, b_v_q;
  logic [20:0]  a_area_q, b_area_q;
  logic [41:0]  a_box_q, b_box_q;
  logic [7:0]   drop_q;
  logic [42:0]  out1_q, out1_d, out2_q, out2_d;
  logic [7:0]   miss1_q, miss1_d, miss2_q, miss2_d;

  assign rise         = vs_q & ~vs_prev_q;
  assign fall         = ~vs_q & vs_prev_q;
  assign req_ready    = gnt;
  assign frame_commit = (state_q == COMMIT);
  assign drop_cnt     = drop_q;
  assign target_pos_out1 = out1_q;
  assign target_pos_out2 = out2_q;

  // A rise seen while finishing a commit is held so the next frame is not missed.
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    pend_d        = pend_q;
    collect_start = 1'b0;
    if (rise && (state_q == DRAIN || state_q == COMMIT)) pend_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (rise || pend_q) begin
          state_d       = COLLECT;
          collect_start = 1'b1;
          pend_d        = 1'b0;
        end
      end
      COLLECT: begin
        if (fall) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        if (drain_q) state_d = COMMIT;
        else         drain_d = 1'b1;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt     = '0;
    gnt_box = '0;
    rr_d    = rr_q;
    found   = 1'b0;
    pos     = 0;
    if (state_q == COLLECT) begin
      for (int unsigned k = 0; k < NR; k++) begin
        pos = 32'(rr_q) + k;
        if (pos >= NR) pos = pos - NR;
        for (int unsigned j = 0; j < NR; j++) begin
          if (!found && pos == j && req_valid[j]) begin
            found   = 1'b1;
            gnt[j]  = 1'b1;
            gnt_box = req_box[j*42 +: 42];
            rr_d    = (j == NR - 1) ? '0 : PW'(j + 1);
          end
        end
      end
    end
  end

  always_comb begin
    s1_ok = (s1_box_q[10:0] <= s1_box_q[31:21]) &&
            (s1_box_q[20:11] <= s1_box_q[41:32]) &&
            ({1'b0, s1_box_q[31:21]} < HLIM) &&
            ({1'b0, s1_box_q[41:32]} < VLIM);
    w     = s1_box_q[31:21] - s1_box_q[10:0] + 11'd1;
    h     = {1'b0, s1_box_q[41:32]} - {1'b0, s1_box_q[20:11]} + 11'd1;
    area  = 21'(w) * 21'(h);
  end

  always_comb begin
    out1_d  = out1_q;
    out2_d  = out2_q;
    miss1_d = miss1_q;
    miss2_d = miss2_q;
    if (state_q == COMMIT) begin
      if (a_v_q) begin
        out1_d  = {1'b1, a_box_q};
        miss1_d = '0;
      end else begin
        miss1_d = (miss1_q == 8'hFF) ? miss1_q : miss1_q + 8'd1;
        if (miss1_d >= HOLD) out1_d[42] = 1'b0;
      end
      if (b_v_q) begin
        out2_d  = {1'b1, b_box_q};
        miss2_d = '0;
      end else begin
        miss2_d = (miss2_q == 8'hFF) ? miss2_q : miss2_q + 8'd1;
        if (miss2_d >= HOLD) out2_d[42] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vs_q      <= 1'b1;
      vs_prev_q <= 1'b1;
      pend_q    <= 1'b0;
      drain_q   <= 1'b0;
      rr_q      <= '0;
      s1_v_q    <= 1'b0;
      s1_box_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_box_q  <= '0;
      s2_area_q <= '0;
      a_v_q     <= 1'b0;
      b_v_q     <= 1'b0;
      a_area_q  <= '0;
      b_area_q  <= '0;
      a_box_q   <= '0;
      b_box_q   <= '0;
      drop_q    <= '0;
      out1_q    <= '0;
      out2_q    <= '0;
      miss1_q   <= '0;
      miss2_q   <= '0;
    end else begin
      vs_q      <= per_frame_vsync;
      vs_prev_q <= vs_q;
      state_q   <= state_d;
      pend_q    <= pend_d;
      drain_q   <= drain_d;
      rr_q      <= rr_d;
      s1_v_q    <= |gnt;
      s1_box_q  <= gnt_box;
      s2_v_q    <= s1_v_q & s1_ok;
      s2_box_q  <= s1_box_q;
      s2_area_q <= area;
      if (collect_start) drop_q <= '0;
      else if (s1_v_q && !s1_ok && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      // Strict compares keep the earlier box ranked higher on equal area.
      if (collect_start) begin
        a_v_q <= 1'b0;
        b_v_q <= 1'b0;
      end else if (s2_v_q) begin
        if (!a_v_q || s2_area_q > a_area_q) begin
          b_v_q    <= a_v_q;
          b_area_q <= a_area_q;
          b_box_q  <= a_box_q;
          a_v_q    <= 1'b1;
          a_area_q <= s2_area_q;
          a_box_q  <= s2_box_q;
        end else if (!b_v_q || s2_area_q > b_area_q) begin
          b_v_q    <= 1'b1;
          b_area_q <= s2_area_q;
          b_box_q  <= s2_box_q;
        end
      end
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      miss1_q <= miss1_d;
      miss2_q <= miss2_d;
    end
  end
endmodule

// File: tb/tb_target_box_scheduler.sv
// Bench for target_box_scheduler: directed frame table, reset/hold/round-robin sequences,
// and random frames checked against a frame-level reference model.
module tb_target_box_scheduler;
  localparam int NR   = 2;
  localparam int HOLD = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            vsync;
  logic [NR-1:0]   req_valid, req_ready;
  logic [NR*42-1:0] req_box;
  logic [42:0]     out1, out2;
  logic            frame_commit;
  logic [7:0]      drop_cnt;

  always #5 clk = ~clk;

  target_box_scheduler #(
    .NUM_REQ(NR), .HOLD_FRAMES(HOLD), .IMG_HDISP(1280), .IMG_VDISP(720)
  ) dut (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(vsync),
    .req_valid(req_valid), .req_box(req_box), .req_ready(req_ready),
    .target_pos_out1(out1), .target_pos_out2(out2),
    .frame_commit(frame_commit), .drop_cnt(drop_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          rr_m;
  logic [42:0] m_out1, m_out2;
  int          m_miss1, m_miss2, m_drop;
  logic [41:0] rq0[$], rq1[$], acc[$];
  int          glog[$];
  logic [42:0] got1, got2;
  logic [7:0]  gotdrop;

  typedef struct {
    logic [41:0] b0; logic v0;
    logic [41:0] b1; logic v1;
    logic [42:0] e1; logic [42:0] e2; logic [7:0] ed;
  } vec_t;
  vec_t tbl[5];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [41:0] mk(int xmin, int ymin, int xmax, int ymax);
    return {ymax[9:0], xmax[10:0], ymin[9:0], xmin[10:0]};
  endfunction

  function automatic bit box_ok(logic [41:0] b);
    return int'(b[10:0]) <= int'(b[31:21]) && int'(b[20:11]) <= int'(b[41:32]) &&
           int'(b[31:21]) < 1280 && int'(b[41:32]) < 720;
  endfunction

  function automatic int area(logic [41:0] b);
    return (int'(b[31:21]) - int'(b[10:0]) + 1) * (int'(b[41:32]) - int'(b[20:11]) + 1);
  endfunction

  function automatic logic [41:0] rnd_box();
    int x0, x1, y0, y1, r;
    r  = $urandom_range(0, 9);
    x0 = $urandom_range(0, 1279);
    x1 = $urandom_range(x0, 1279);
    y0 = $urandom_range(0, 719);
    y1 = $urandom_range(y0, 719);
    if (r == 8) x1 = $urandom_range(1280, 2047);
    else if (r == 9) y0 = y1 + 1;
    return mk(x0, y0, x1, y1);
  endfunction

  task automatic slot_upd(input int idx, inout logic [42:0] o, inout int miss);
    if (idx >= 0) begin
      o    = {1'b1, acc[idx]};
      miss = 0;
    end else begin
      if (miss < 255) miss++;
      if (miss >= HOLD) o[42] = 1'b0;
    end
  endtask

  // Stable top-2 by area over the accepted boxes of the frame, then slot persistence.
  task automatic model_commit();
    int ia, ib;
    ia = -1; ib = -1; m_drop = 0;
    foreach (acc[i]) if (!box_ok(acc[i]) && m_drop < 255) m_drop++;
    foreach (acc[i]) if (box_ok(acc[i]) && (ia < 0 || area(acc[i]) > area(acc[ia]))) ia = i;
    foreach (acc[i])
      if (box_ok(acc[i]) && i != ia && (ib < 0 || area(acc[i]) > area(acc[ib]))) ib = i;
    slot_upd(ia, m_out1, m_miss1);
    slot_upd(ib, m_out2, m_miss2);
  endtask

  // vsync high for H cycles; H grant slots follow the 2-cycle sync/edge delay.
  task automatic run_frame(input int H);
    logic [NR-1:0] eg;
    logic [42:0]   p1;
    acc.delete();
    glog.delete();
    for (int c = 0; c <= H + 1; c++) begin
      vsync     = (c < H);
      req_valid = {rq1.size() > 0, rq0.size() > 0};
      req_box   = {(rq1.size() > 0) ? rq1[0] : 42'd0, (rq0.size() > 0) ? rq0[0] : 42'd0};
      eg = '0;
      if (c >= 2) begin
        for (int k = 0; k < NR; k++) begin
          int i;
          i = (rr_m + k) % NR;
          if (eg == '0 && req_valid[i]) eg[i] = 1'b1;
        end
      end
      #1;
      chk("req_ready", 64'(req_ready), 64'(eg));
      if (req_ready != '0) glog.push_back(req_ready[1] ? 1 : 0);
      tick();
      if (eg[0]) begin acc.push_back(rq0.pop_front()); rr_m = 1; end
      else if (eg[1]) begin acc.push_back(rq1.pop_front()); rr_m = 0; end
    end
    req_valid = '0;
    req_box   = '0;
    rq0.delete();
    rq1.delete();
    p1 = m_out1;
    model_commit();
    chk("commit_early", 64'(frame_commit), 64'(0));
    tick();
    chk("commit_early", 64'(frame_commit), 64'(0));
    tick();
    chk("commit_pulse", 64'(frame_commit), 64'(1));
    chk("out1_before_update", 64'(out1), 64'(p1));
    tick();
    chk("commit_end", 64'(frame_commit), 64'(0));
    got1 = out1; got2 = out2; gotdrop = drop_cnt;
    chk("out1_model", 64'(out1), 64'(m_out1));
    chk("out2_model", 64'(out2), 64'(m_out2));
    chk("drop_model", 64'(drop_cnt), 64'(m_drop));
    tick();
    tick();
  endtask

  initial begin
    logic [41:0] bA, bB, bC, bD, bE, bF, bG, bH, bK;
    logic        seen;

    bA = mk(100, 50, 300, 150);  bB = mk(400, 200, 420, 210);
    bC = mk(500, 10, 400, 20);   bD = mk(0, 0, 1280, 5);
    bE = mk(0, 0, 99, 99);       bF = mk(200, 300, 299, 399);
    bG = mk(10, 10, 10, 10);     bH = mk(0, 0, 10, 720);
    bK = mk(5, 6, 7, 8);
    tbl[0] = '{bA, 1'b1, bB, 1'b1, {1'b1, bA}, {1'b1, bB}, 8'd0};
    tbl[1] = '{bC, 1'b1, bD, 1'b1, {1'b1, bA}, {1'b1, bB}, 8'd2};
    tbl[2] = '{bE, 1'b1, bF, 1'b1, {1'b1, bE}, {1'b1, bF}, 8'd0};
    tbl[3] = '{42'd0, 1'b0, bG, 1'b1, {1'b1, bG}, {1'b1, bF}, 8'd0};
    tbl[4] = '{bH, 1'b1, 42'd0, 1'b0, {1'b1, bG}, {1'b1, bF}, 8'd1};

    rst_n = 1'b0; vsync = 1'b0; req_valid = '0; req_box = '0;
    repeat (3) tick();
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_out1", 64'(out1), 64'(0));
    chk("rst_out2", 64'(out2), 64'(0));
    chk("rst_commit", 64'(frame_commit), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    rst_n = 1'b1;
    tick(); tick();

    // Reset in the middle of a collecting frame with requests held.
    vsync = 1'b1; req_valid = 2'b11; req_box = {bB, bA};
    repeat (6) tick();
    chk("collect_active", 64'(|req_ready), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'(0));
    chk("midrst_out1", 64'(out1), 64'(0));
    chk("midrst_out2", 64'(out2), 64'(0));
    chk("midrst_drop", 64'(drop_cnt), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("postrst_ready", 64'(req_ready), 64'(0));
    vsync = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (frame_commit) seen = 1'b1;
    end
    chk("postrst_no_commit", 64'(seen), 64'(0));
    chk("postrst_out1", 64'(out1), 64'(0));
    req_valid = '0;
    rr_m = 0; m_out1 = '0; m_out2 = '0; m_miss1 = 0; m_miss2 = 0;

    for (int t = 0; t < 5; t++) begin
      if (tbl[t].v0) rq0.push_back(tbl[t].b0);
      if (tbl[t].v1) rq1.push_back(tbl[t].b1);
      run_frame(4);
      chk("tbl_out1", 64'(got1), 64'(tbl[t].e1));
      chk("tbl_out2", 64'(got2), 64'(tbl[t].e2));
      chk("tbl_drop", 64'(gotdrop), 64'(tbl[t].ed));
    end

    // One detection then HOLD empty frames.
    rq1.push_back(bK);
    run_frame(4);
    chk("hold_det", 64'(got1), 64'({1'b1, bK}));
    for (int k = 1; k <= HOLD; k++) begin
      run_frame(3);
      chk("hold_flag1", 64'(got1[42]), 64'(k < HOLD));
      chk("hold_coords1", 64'(got1[41:0]), 64'(bK));
    end
    chk("hold_out2", 64'(got2), 64'({1'b0, bF}));

    // Both requesters continuously valid: strict alternation.
    for (int i = 0; i < 6; i++) begin
      rq0.push_back(mk(i, i, i + 10, i + 10));
      rq1.push_back(mk(i + 50, i, i + 60, i + 30));
    end
    run_frame(8);
    chk("rr_count", 64'(glog.size()), 64'(8));
    foreach (glog[i]) chk("rr_order", 64'(glog[i]), 64'(i % 2));

    for (int f = 0; f < 25; f++) begin
      int n0, n1;
      n0 = $urandom_range(0, 5);
      n1 = $urandom_range(0, 5);
      for (int i = 0; i < n0; i++) rq0.push_back(rnd_box());
      for (int i = 0; i < n1; i++) rq1.push_back(rnd_box());
      run_frame($urandom_range(2, 12));
    end

    // Drop counter saturation.
    for (int i = 0; i < 150; i++) begin
      rq0.push_back(mk(0, 0, 1300, 5));
      rq1.push_back(mk(9, 0, 3, 5));
    end
    run_frame(300);
    chk("drop_sat", 64'(gotdrop), 64'(255));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
